// File: rtl/rx_rr_arb.sv
// Round-robin frame arbiter: grants one rx_phy channel at a time for a whole frame
// and forwards its words to the shared RX FIFO write port.
module rx_rr_arb #(
  parameter int PHY_NUM   = 10,
  parameter int MAX_WORDS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reg_flush,
  input  logic [31:0]           reg_mask,
  input  logic                  rx_almost_full,
  input  logic [PHY_NUM-1:0]    rx_req,
  input  logic [PHY_NUM-1:0]    rx_last,
  input  logic [PHY_NUM*32-1:0] rx_datx,
  output logic [PHY_NUM-1:0]    rx_gnt,
  output logic                  rx_vld,
  output logic [31:0]           rx_dat,
  output logic                  rx_abort,
  output logic [15:0]           frm_cnt,
  output logic [7:0]            abort_cnt
);

  localparam int PTR_W = (PHY_NUM > 1) ? $clog2(PHY_NUM) : 1;
  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(PHY_NUM - 1);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_WORDS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                 state_r;
  logic [PTR_W-1:0]       rr_ptr_r;
  logic [PTR_W-1:0]       gnt_idx_r;
  logic [CNT_W-1:0]       word_cnt_r;

  logic [PHY_NUM-1:0]     elig_s;
  logic [2*PHY_NUM-1:0]   dbl_s;
  logic [PHY_NUM-1:0]     rot_s;
  logic                   pick_vld_s;
  logic [PTR_W-1:0]       off_s;
  logic [PTR_W:0]         sum_s;
  logic [PTR_W-1:0]       pick_idx_s;
  logic [PHY_NUM-1:0]     pick_oh_s;
  logic [PTR_W-1:0]       next_ptr_s;
  logic [31:0]            sel_dat_s;
  logic                   sel_last_s;
  logic                   unused_mask_s;

  assign elig_s        = rx_req & ~reg_mask[PHY_NUM-1:0];
  assign unused_mask_s = ^reg_mask;

  // Rotate the eligible vector so that rr_ptr sits at bit 0, then take the lowest set bit.
  always_comb begin
    dbl_s      = {elig_s, elig_s} >> rr_ptr_r;
    rot_s      = dbl_s[PHY_NUM-1:0];
    pick_vld_s = 1'b0;
    off_s      = {PTR_W{1'b0}};
    for (int k = PHY_NUM - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        pick_vld_s = 1'b1;
        off_s      = PTR_W'(k);
      end else begin
        pick_vld_s = pick_vld_s;
        off_s      = off_s;
      end
    end
    sum_s = {1'b0, rr_ptr_r} + {1'b0, off_s};
    if (sum_s >= (PTR_W+1)'(PHY_NUM)) begin
      pick_idx_s = PTR_W'(sum_s - (PTR_W+1)'(PHY_NUM));
    end else begin
      pick_idx_s = sum_s[PTR_W-1:0];
    end
  end

  // One-hot of the winner and the data/last mux of the current grant.
  always_comb begin
    pick_oh_s  = {PHY_NUM{1'b0}};
    sel_dat_s  = 32'h0000_0000;
    sel_last_s = 1'b0;
    for (int j = 0; j < PHY_NUM; j++) begin
      pick_oh_s[j] = (pick_idx_s == PTR_W'(j));
      sel_dat_s    = sel_dat_s | ({32{rx_gnt[j]}} & rx_datx[32*j +: 32]);
      sel_last_s   = sel_last_s | (rx_gnt[j] & rx_last[j]);
    end
    if (gnt_idx_r == LAST_IDX) begin
      next_ptr_s = {PTR_W{1'b0}};
    end else begin
      next_ptr_s = gnt_idx_r + PTR_W'(1);
    end
  end

  // Arbiter FSM with registered grant, output word and status counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      rr_ptr_r   <= {PTR_W{1'b0}};
      gnt_idx_r  <= {PTR_W{1'b0}};
      word_cnt_r <= {CNT_W{1'b0}};
      rx_gnt     <= {PHY_NUM{1'b0}};
      rx_vld     <= 1'b0;
      rx_dat     <= 32'h0000_0000;
      rx_abort   <= 1'b0;
      frm_cnt    <= 16'h0000;
      abort_cnt  <= 8'h00;
    end else if (reg_flush) begin
      state_r    <= IDLE;
      rr_ptr_r   <= {PTR_W{1'b0}};
      gnt_idx_r  <= {PTR_W{1'b0}};
      word_cnt_r <= {CNT_W{1'b0}};
      rx_gnt     <= {PHY_NUM{1'b0}};
      rx_vld     <= 1'b0;
      rx_dat     <= 32'h0000_0000;
      rx_abort   <= 1'b0;
      frm_cnt    <= 16'h0000;
      abort_cnt  <= 8'h00;
    end else begin
      rx_abort <= 1'b0;
      rx_vld   <= |rx_gnt;
      rx_dat   <= sel_dat_s;
      case (state_r)
        IDLE: begin
          if (pick_vld_s && !rx_almost_full) begin
            rx_gnt     <= pick_oh_s;
            gnt_idx_r  <= pick_idx_s;
            word_cnt_r <= {CNT_W{1'b0}};
            state_r    <= XFER;
          end else begin
            state_r <= IDLE;
          end
        end
        XFER: begin
          word_cnt_r <= word_cnt_r + CNT_W'(1);
          // rx_last wins over the watchdog when both land on the same word.
          if (sel_last_s) begin
            rx_gnt   <= {PHY_NUM{1'b0}};
            frm_cnt  <= frm_cnt + 16'd1;
            rr_ptr_r <= next_ptr_s;
            state_r  <= IDLE;
          end else if (word_cnt_r == WD_LIMIT) begin
            rx_gnt    <= {PHY_NUM{1'b0}};
            rx_abort  <= 1'b1;
            abort_cnt <= (abort_cnt == 8'hFF) ? 8'hFF : abort_cnt + 8'd1;
            rr_ptr_r  <= next_ptr_s;
            state_r   <= IDLE;
          end else begin
            state_r <= XFER;
          end
        end
        default: begin
          rx_gnt  <= {PHY_NUM{1'b0}};
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rx_rr_arb.md
Name: rx_rr_arb

Overview:
- Round-robin frame arbiter that shares the single RX FIFO write port between PHY_NUM rx_phy receivers.
- Sits between the rx_phy array and the RX FIFO.
- Grants one receiver at a time for a whole frame and muxes that receiver's words onto rx_vld/rx_dat.
- Adds FIFO backpressure at frame boundaries, per-channel masking, a runaway-frame watchdog and status counters.

Parameters:
PHY_NUM, 10, number of receiver channels (1..32)
MAX_WORDS, 5, maximum words per frame (RXID, TaskID_H, TaskID_L, TIME, NONCE); exceeding it aborts the frame

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
reg_flush  in  1  synchronous flush of arbiter state and counters
reg_mask  in  32  bit i=1 excludes channel i from arbitration (bits >= PHY_NUM ignored)
rx_almost_full  in  1  FIFO almost full; blocks new grants only
rx_req  in  PHY_NUM  per-channel frame-ready request; held high until granted
rx_last  in  PHY_NUM  per-channel last-word flag, valid while granted
rx_datx  in  PHY_NUM*32  per-channel data word, channel i at [32*i+31:32*i]
rx_gnt  out  PHY_NUM  one-hot grant; channel streams one word per cycle while set
rx_vld  out  1  registered output word valid
rx_dat  out  32  registered output word
rx_abort  out  1  one-cycle pulse when a frame is aborted by the watchdog
frm_cnt  out  16  completed-frame count, wraps at 0xFFFF -> 0
abort_cnt  out  8  aborted-frame count, saturates at 0xFF

Behaviour:
- Reset (async) and flush (sync) values: rx_gnt=0, rx_vld=0, rx_dat=0, rx_abort=0, frm_cnt=0, abort_cnt=0, state=IDLE, rr_ptr=0, word_cnt=0. Flush takes priority over every other event in the same cycle.
- States:
  - IDLE: eligible = rx_req & ~reg_mask[PHY_NUM-1:0].
    - If eligible!=0 and rx_almost_full=0, pick the first set bit searching rr_ptr, rr_ptr+1, ... modulo PHY_NUM.
    - Set rx_gnt to that one-hot at the next edge, word_cnt=0, go XFER.
    - Otherwise stay in IDLE.
  - XFER: every cycle, capture rx_datx of the granted channel and increment word_cnt.
    - If rx_last of the granted channel is set: frame completes. Clear rx_gnt, frm_cnt+1, rr_ptr=granted index+1 (wraps PHY_NUM-1 -> 0), go IDLE.
    - Else if word_cnt+1 == MAX_WORDS: frame is aborted. Clear rx_gnt, pulse rx_abort, abort_cnt+1 (saturating), rr_ptr=granted+1, go IDLE.
- Output mux: rx_vld <= |rx_gnt; rx_dat <= granted channel's word when rx_gnt!=0, else 0.
  - Latency: request seen in IDLE at cycle t -> rx_gnt high at t+1 -> first rx_vld/rx_dat at t+2.
  - Last word appears on rx_dat one cycle after its rx_last cycle.
- Aborted frame: words already forwarded remain forwarded. The word captured in the abort cycle is forwarded with rx_vld=1.
- Minimum inter-frame gap: one IDLE cycle between frames, so back-to-back frames give one rx_vld=0 bubble.
- rx_almost_full rising during XFER does not stop the frame. It only blocks the next grant.
- reg_mask bit set during XFER for the granted channel does not cut the frame. It only affects the next arbitration.
- rx_req dropping while granted is ignored; completion is only by rx_last or the watchdog.
- Simultaneous rx_last and the watchdog limit in the same cycle: this counts as completion, not abort.
- Requests from channels >= PHY_NUM do not exist.
- rx_gnt is one-hot or zero at all times.

Test Plan:
1. Reset, then channel 3 requests with rx_datx[3] = 0x1,0x2,0x3,0x4,0x5 and rx_last on the 5th cycle -> rx_gnt=0x008 one cycle later; rx_vld high for exactly 5 cycles carrying 0x1..0x5; frm_cnt=1; rr_ptr=4.
2. Channels 0, 2 and 9 request continuously with 5-word frames, rr_ptr=0 -> grant order 0, 2, 9, 0, 2; one-cycle rx_vld gap between frames; frm_cnt=5.
3. rx_almost_full=1 with channel 1 requesting -> rx_gnt stays 0 for 20 cycles. Drop almost_full -> grant 0x002 next cycle. Raise almost_full mid-frame -> all 5 words still delivered.
4. reg_mask=0x004, channels 2 and 5 request -> only channel 5 is granted. Clear the mask -> channel 2 is granted after channel 5 completes.
5. Channel 4 granted and never asserts rx_last -> rx_gnt clears after 5 words; rx_abort pulses one cycle; abort_cnt=1; next requester is granted. Repeat 256 times -> abort_cnt stays 0xFF.
6. reg_flush asserted on word 3 of a frame -> next cycle rx_gnt=0, rx_vld=0, frm_cnt=0, rr_ptr=0. Async rst mid-frame -> outputs clear immediately without waiting for a clock edge.
